calc_key_sequencer: RTL and testbench

- Upstream command stage for the 4-bit `calculator` block (a[3:0], b[3:0], oper[2:0] in; out[7:0] out).
- Accepts a stream of key tokens over a valid/ready handshake and assembles operand A, operator and operand B.
- Drives the assembled values onto the calculator inputs, waits a settle window, then captures `out` into a registered result with a valid/ready output handshake.

---
 rtl/calc_key_sequencer.sv | 175 +++++++++++++++++
 tb/tb_calc_key_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_key_sequencer.sv
// calc_key_sequencer: assembles digit / operator / equals key tokens into calculator
// operands, lets the calculator settle, then holds the captured result for a consumer.
module calc_key_sequencer #(
  parameter int W_OPND        = 4,
  parameter int W_OPER        = 3,
  parameter int W_RES         = 8,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_valid,
  output logic              key_ready,
  input  logic [1:0]        key_type,
  input  logic [3:0]        key_data,
  output logic [W_OPND-1:0] calc_a,
  output logic [W_OPND-1:0] calc_b,
  output logic [W_OPER-1:0] calc_oper,
  input  logic [W_RES-1:0]  calc_out,
  output logic [W_RES-1:0]  result,
  output logic              result_valid,
  input  logic              result_ready,
  output logic              busy,
  output logic              err
);

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  localparam logic [1:0] K_DIGIT  = 2'd0;
  localparam logic [1:0] K_OPER   = 2'd1;
  localparam logic [1:0] K_EQUALS = 2'd2;
  localparam logic [1:0] K_CLEAR  = 2'd3;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_OP   = 3'd1,
    S_B    = 3'd2,
    S_EQ   = 3'd3,
    S_EXEC = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [W_OPND-1:0]  a_q, a_d;
  logic [W_OPND-1:0]  b_q, b_d;
  logic [W_OPER-1:0]  oper_q, oper_d;
  logic [W_RES-1:0]   result_q, result_d;
  logic               result_valid_q, result_valid_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               accept;
  logic [W_OPND-1:0]  digit;
  logic [W_OPER-1:0]  oper_code;

  assign key_ready = (state_q == S_A) || (state_q == S_OP) ||
                     (state_q == S_B) || (state_q == S_EQ);
  assign busy      = (state_q == S_EXEC) || (state_q == S_DONE);
  assign accept    = key_valid && key_ready;
  assign digit     = W_OPND'(key_data);
  assign oper_code = W_OPER'(key_data[2:0]);

  assign calc_a       = a_q;
  assign calc_b       = b_q;
  assign calc_oper    = oper_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign err          = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_A;
      a_q            <= '0;
      b_q            <= '0;
      oper_q         <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      err_q          <= 1'b0;
      cnt_q          <= '0;
    end else begin
      state_q        <= state_d;
      a_q            <= a_d;
      b_q            <= b_d;
      oper_q         <= oper_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      err_q          <= err_d;
      cnt_q          <= cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    a_d            = a_q;
    b_d            = b_q;
    oper_d         = oper_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    err_d          = 1'b0;
    cnt_d          = cnt_q;

    // An illegal token is consumed but only raises err; nothing else moves.
    if (accept) begin
      if (key_type == K_CLEAR) begin
        a_d     = '0;
        b_d     = '0;
        oper_d  = '0;
        state_d = S_A;
      end else if (key_type == K_OPER && key_data[3]) begin
        err_d = 1'b1;
      end else begin
        case (state_q)
          S_A: begin
            if (key_type == K_DIGIT) begin
              a_d     = digit;
              state_d = S_OP;
            end else begin
              err_d = 1'b1;
            end
          end
          S_OP: begin
            if (key_type == K_DIGIT) begin
              a_d = digit;
            end else if (key_type == K_OPER) begin
              oper_d  = oper_code;
              state_d = S_B;
            end else begin
              err_d = 1'b1;
            end
          end
          S_B: begin
            if (key_type == K_DIGIT) begin
              b_d     = digit;
              state_d = S_EQ;
            end else begin
              err_d = 1'b1;
            end
          end
          S_EQ: begin
            if (key_type == K_DIGIT) begin
              b_d = digit;
            end else if (key_type == K_EQUALS) begin
              cnt_d   = SETTLE_LOAD;
              state_d = S_EXEC;
            end else begin
              err_d = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end

    // Operands stay frozen while the calculator settles and while the result waits.
    case (state_q)
      S_EXEC: begin
        if (cnt_q == '0) begin
          result_d       = calc_out;
          result_valid_d = 1'b1;
          state_d        = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        if (result_ready) begin
          result_valid_d = 1'b0;
          state_d        = S_A;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_calc_key_sequencer.sv
// tb_calc_key_sequencer: directed plus randomized token streams against a
// behavioural key-entry model and a stub calculator.
module tb_calc_key_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] key_type = 2'd0;
  logic [3:0] key_data = 4'd0;

  logic       key_valid = 1'b0, key_ready, result_valid, result_ready = 1'b0, busy, err;
  logic [3:0] calc_a, calc_b;
  logic [2:0] calc_oper;
  logic [7:0] calc_out, result;

  logic       key_valid4 = 1'b0, key_ready4, result_valid4, result_ready4 = 1'b0, busy4, err4;
  logic [3:0] calc_a4, calc_b4;
  logic [2:0] calc_oper4;
  logic [7:0] calc_out4, result4;

  int cyc = 0;
  int pass_count = 0;
  int check_count = 0;
  int last_acc = 0;
  bit last_exp_err = 1'b0;

  int m_a = 0, m_b = 0, m_op = 0, m_stage = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] calc_stub(input logic [3:0] a, input logic [3:0] b,
                                           input logic [2:0] op);
    case (op)
      3'd0:    return 8'(a) + 8'(b);
      3'd2:    return 8'(a) * 8'(b);
      default: return {a, b};
    endcase
  endfunction

  assign calc_out  = calc_stub(calc_a, calc_b, calc_oper);
  assign calc_out4 = calc_stub(calc_a4, calc_b4, calc_oper4);

  calc_key_sequencer #(.W_OPND(4), .W_OPER(3), .W_RES(8), .SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_ready(key_ready),
    .key_type(key_type), .key_data(key_data), .calc_a(calc_a), .calc_b(calc_b),
    .calc_oper(calc_oper), .calc_out(calc_out), .result(result),
    .result_valid(result_valid), .result_ready(result_ready), .busy(busy), .err(err)
  );

  calc_key_sequencer #(.W_OPND(4), .W_OPER(3), .W_RES(8), .SETTLE_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst), .key_valid(key_valid4), .key_ready(key_ready4),
    .key_type(key_type), .key_data(key_data), .calc_a(calc_a4), .calc_b(calc_b4),
    .calc_oper(calc_oper4), .calc_out(calc_out4), .result(result4),
    .result_valid(result_valid4), .result_ready(result_ready4), .busy(busy4), .err(err4)
  );

  // Key-entry rules: stage counts fields entered (0 none, 1 A, 2 A+op, 3 A+op+B, 4 computing).
  function automatic bit model_key(input int t, input int d);
    if (t == 3) begin
      m_a = 0; m_b = 0; m_op = 0; m_stage = 0;
      return 1'b0;
    end
    if (t == 1 && d >= 8) return 1'b1;
    if (t == 0 && (m_stage == 0 || m_stage == 1)) begin m_a = d; m_stage = 1; return 1'b0; end
    if (t == 0 && (m_stage == 2 || m_stage == 3)) begin m_b = d; m_stage = 3; return 1'b0; end
    if (t == 1 && m_stage == 1) begin m_op = d; m_stage = 2; return 1'b0; end
    if (t == 2 && m_stage == 3) begin m_stage = 4; return 1'b0; end
    return 1'b1;
  endfunction

  task automatic send(input logic [1:0] t, input logic [3:0] d, input bit keep, input bit to4);
    int waitc;
    @(negedge clk);
    key_type = t;
    key_data = d;
    if (to4) key_valid4 = 1'b1; else key_valid = 1'b1;
    waitc = 0;
    while (!(to4 ? key_ready4 : key_ready) && waitc < 100) begin
      @(negedge clk);
      waitc++;
    end
    if (!(to4 ? key_ready4 : key_ready)) begin
      $display("[TB] FAIL accept_timeout: key_ready got 0 required 1 (type %0d data %0d)", t, d);
      check_count++;
    end
    @(posedge clk);
    #1;
    last_acc = cyc;
    if (!to4) last_exp_err = model_key(int'(t), int'(d));
    if (!keep) begin
      key_valid  = 1'b0;
      key_valid4 = 1'b0;
    end
  endtask

  task automatic wait_rv(input bit to4, output int edges);
    edges = 0;
    while (!(to4 ? result_valid4 : result_valid) && edges < 50) begin
      @(posedge clk);
      #1;
      edges++;
    end
    if (!(to4 ? result_valid4 : result_valid)) begin
      $display("[TB] FAIL result_timeout: result_valid got 0 required 1");
      check_count++;
    end
  endtask

  task automatic take_result(input bit to4);
    @(negedge clk);
    if (to4) result_ready4 = 1'b1; else result_ready = 1'b1;
    @(posedge clk);
    #1;
    result_ready  = 1'b0;
    result_ready4 = 1'b0;
    if (!to4) m_stage = 0;
  endtask

  task automatic test_reset();
    #1;
    check_count++; if ({calc_a, calc_b, calc_oper} !== 11'd0) $display("[TB] FAIL reset_operands: got %0h required 0", {calc_a, calc_b, calc_oper}); else pass_count++;
    check_count++; if (result !== 8'd0) $display("[TB] FAIL reset_result: got %0h required 0", result); else pass_count++;
    check_count++; if ({result_valid, err, busy} !== 3'b000) $display("[TB] FAIL reset_flags: got %b required 000", {result_valid, err, busy}); else pass_count++;
    check_count++; if (key_ready !== 1'b1) $display("[TB] FAIL reset_key_ready: got %b required 1", key_ready); else pass_count++;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add();
    int edges;
    send(2'd0, 4'd9, 0, 0);
    send(2'd1, 4'd0, 0, 0);
    send(2'd0, 4'd3, 0, 0);
    send(2'd2, 4'd0, 0, 0);
    check_count++; if ({busy, key_ready, result_valid} !== 3'b100) $display("[TB] FAIL add_exec_flags: got %b required 100", {busy, key_ready, result_valid}); else pass_count++;
    wait_rv(0, edges);
    check_count++; if (edges !== 1) $display("[TB] FAIL add_latency: got %0d edges required 1", edges); else pass_count++;
    check_count++; if (result !== 8'h0C) $display("[TB] FAIL add_result: got %0h required 0c", result); else pass_count++;
    check_count++; if ({calc_a, calc_b} !== 8'h93) $display("[TB] FAIL add_operands: got %0h required 93", {calc_a, calc_b}); else pass_count++;
    take_result(0);
    check_count++; if ({result_valid, key_ready} !== 2'b01) $display("[TB] FAIL add_handshake: got %b required 01", {result_valid, key_ready}); else pass_count++;
  endtask

  task automatic test_mul_hold();
    int edges;
    send(2'd0, 4'd9, 0, 0);
    send(2'd0, 4'd5, 0, 0);
    send(2'd1, 4'd2, 0, 0);
    send(2'd0, 4'd3, 0, 0);
    send(2'd0, 4'd4, 0, 0);
    send(2'd2, 4'd0, 0, 0);
    wait_rv(0, edges);
    check_count++; if ({calc_a, calc_b, calc_oper} !== {4'd5, 4'd4, 3'd2}) $display("[TB] FAIL mul_operands: got %0h required %0h", {calc_a, calc_b, calc_oper}, {4'd5, 4'd4, 3'd2}); else pass_count++;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check_count++; if ({result_valid, result, key_ready} !== {1'b1, 8'h14, 1'b0}) $display("[TB] FAIL mul_hold: got %0h required %0h", {result_valid, result, key_ready}, {1'b1, 8'h14, 1'b0}); else pass_count++;
    end
    take_result(0);
    check_count++; if ({result_valid, key_ready, result} !== {1'b0, 1'b1, 8'h14}) $display("[TB] FAIL mul_release: got %0h required %0h", {result_valid, key_ready, result}, {1'b0, 1'b1, 8'h14}); else pass_count++;
  endtask

  task automatic test_errors();
    int edges;
    send(2'd2, 4'd0, 0, 0);
    check_count++; if ({err, key_ready, calc_a} !== {1'b1, 1'b1, 4'd5}) $display("[TB] FAIL err_equals_in_a: got %0h required %0h", {err, key_ready, calc_a}, {1'b1, 1'b1, 4'd5}); else pass_count++;
    @(posedge clk);
    #1;
    check_count++; if (err !== 1'b0) $display("[TB] FAIL err_one_cycle: got %b required 0", err); else pass_count++;
    send(2'd0, 4'd4, 0, 0);
    send(2'd1, 4'd8, 0, 0);
    check_count++; if ({err, calc_oper, calc_a} !== {1'b1, 3'd2, 4'd4}) $display("[TB] FAIL err_bad_oper: got %0h required %0h", {err, calc_oper, calc_a}, {1'b1, 3'd2, 4'd4}); else pass_count++;
    send(2'd1, 4'd0, 0, 0);
    send(2'd1, 4'd0, 0, 0);
    check_count++; if ({err, calc_oper, calc_b} !== {1'b1, 3'd0, 4'd4}) $display("[TB] FAIL err_oper_in_b: got %0h required %0h", {err, calc_oper, calc_b}, {1'b1, 3'd0, 4'd4}); else pass_count++;
    send(2'd0, 4'd6, 0, 0);
    send(2'd2, 4'd0, 0, 0);
    wait_rv(0, edges);
    check_count++; if (result !== 8'h0A) $display("[TB] FAIL err_recovery_result: got %0h required 0a", result); else pass_count++;
    take_result(0);
  endtask

  task automatic test_clear();
    int edges;
    send(2'd0, 4'd7, 0, 0);
    send(2'd1, 4'd1, 0, 0);
    send(2'd3, 4'd0, 0, 0);
    check_count++; if ({err, calc_a, calc_b, calc_oper, busy, key_ready} !== {1'b0, 11'd0, 1'b0, 1'b1}) $display("[TB] FAIL clear_state: got %0h required %0h", {err, calc_a, calc_b, calc_oper, busy, key_ready}, {1'b0, 11'd0, 1'b0, 1'b1}); else pass_count++;
    send(2'd0, 4'd2, 0, 0);
    send(2'd1, 4'd2, 0, 0);
    send(2'd0, 4'd7, 0, 0);
    send(2'd2, 4'd0, 0, 0);
    wait_rv(0, edges);
    check_count++; if (result !== 8'h0E) $display("[TB] FAIL clear_then_mul: got %0h required 0e", result); else pass_count++;
    take_result(0);
  endtask

  task automatic test_back_to_back();
    int c0, c1, c2, c3;
    @(negedge clk);
    result_ready = 1'b1;
    send(2'd0, 4'd2, 1, 0); c0 = last_acc;
    send(2'd1, 4'd0, 1, 0); c1 = last_acc;
    send(2'd0, 4'd6, 1, 0); c2 = last_acc;
    send(2'd2, 4'd0, 1, 0); c3 = last_acc;
    check_count++; if ({c1 - c0, c2 - c1, c3 - c2} !== {32'd1, 32'd1, 32'd1}) $display("[TB] FAIL b2b_consecutive: got %0d %0d %0d required 1 1 1", c1 - c0, c2 - c1, c3 - c2); else pass_count++;
    m_stage = 0;
    send(2'd0, 4'd1, 0, 0);
    check_count++; if (last_acc - c3 !== 3) $display("[TB] FAIL b2b_stall: got %0d edges required 3", last_acc - c3); else pass_count++;
    check_count++; if ({result, result_valid, calc_a, err} !== {8'h08, 1'b0, 4'd1, 1'b0}) $display("[TB] FAIL b2b_after: got %0h required %0h", {result, result_valid, calc_a, err}, {8'h08, 1'b0, 4'd1, 1'b0}); else pass_count++;
    result_ready = 1'b0;
  endtask

  task automatic test_random();
    int r, t, d, edges, dly;
    logic [7:0] exp_res;
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 9);
      t = (r < 5) ? 0 : (r < 7) ? 1 : (r < 9) ? 2 : 3;
      d = $urandom_range(0, 15);
      send(2'(t), 4'(d), 0, 0);
      check_count++; if (err !== last_exp_err) $display("[TB] FAIL rand_err[%0d]: got %b required %b", i, err, last_exp_err); else pass_count++;
      check_count++; if ({calc_a, calc_b, calc_oper} !== {4'(m_a), 4'(m_b), 3'(m_op)}) $display("[TB] FAIL rand_operands[%0d]: got %0h required %0h", i, {calc_a, calc_b, calc_oper}, {4'(m_a), 4'(m_b), 3'(m_op)}); else pass_count++;
      if (m_stage == 4) begin
        wait_rv(0, edges);
        exp_res = (m_op == 0) ? 8'(m_a + m_b) : (m_op == 2) ? 8'(m_a * m_b) : {4'(m_a), 4'(m_b)};
        check_count++; if (result !== exp_res) $display("[TB] FAIL rand_result[%0d]: got %0h required %0h", i, result, exp_res); else pass_count++;
        dly = $urandom_range(0, 3);
        repeat (dly) @(posedge clk);
        take_result(0);
        check_count++; if (result_valid !== 1'b0) $display("[TB] FAIL rand_release[%0d]: got %b required 0", i, result_valid); else pass_count++;
      end
    end
  endtask

  task automatic test_settle4_reset();
    int edges, rose;
    send(2'd0, 4'd6, 0, 1);
    send(2'd1, 4'd0, 0, 1);
    send(2'd0, 4'd7, 0, 1);
    send(2'd2, 4'd0, 0, 1);
    edges = 0;
    wait_rv(1, edges);
    check_count++; if (edges !== 4) $display("[TB] FAIL settle4_latency: got %0d edges required 4", edges); else pass_count++;
    check_count++; if (result4 !== 8'h0D) $display("[TB] FAIL settle4_result: got %0h required 0d", result4); else pass_count++;
    take_result(1);
    send(2'd0, 4'd3, 0, 1);
    send(2'd1, 4'd2, 0, 1);
    send(2'd0, 4'd5, 0, 1);
    send(2'd2, 4'd0, 0, 1);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_count++; if ({calc_a4, calc_b4, calc_oper4, result4, result_valid4, busy4, key_ready4} !== {11'd0, 8'd0, 1'b0, 1'b0, 1'b1}) $display("[TB] FAIL async_reset: got %0h required %0h", {calc_a4, calc_b4, calc_oper4, result4, result_valid4, busy4, key_ready4}, {11'd0, 8'd0, 1'b0, 1'b0, 1'b1}); else pass_count++;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_a = 0; m_b = 0; m_op = 0; m_stage = 0;
    rose = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (result_valid4) rose++;
    end
    check_count++; if (rose !== 0) $display("[TB] FAIL reset_no_result: result_valid high on %0d edges required 0", rose); else pass_count++;
    check_count++; if (key_ready4 !== 1'b1) $display("[TB] FAIL reset_key_ready4: got %b required 1", key_ready4); else pass_count++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul_hold();
    test_errors();
    test_clear();
    test_back_to_back();
    test_random();
    test_settle4_reset();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
